// File: rtl/div_plus_if.sv
// Request/result bundle between the EX stage and the sequential divider.
// The EX-stage side is the master; the divider is the slave.
interface div_plus_if;
    logic        start_i;
    logic        div_sign;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output start_i,
        output div_sign,
        output opdata1_i,
        output opdata2_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  start_i,
        input  div_sign,
        input  opdata1_i,
        input  opdata2_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_plus.sv
// Sequential 32-bit radix-2 restoring divider (DIV/DIVU).
// result_o = {remainder, quotient}; one iteration per cycle, 32 iterations,
// divide-by-zero short-circuits to a zero result. start_i is held for the
// whole stall; dropping it aborts without touching the result register.
module div_plus (
    input  logic      clk,
    input  logic      resetn,
    div_plus_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg;
    logic [63:0] work_reg;
    logic [31:0] divisor_reg;
    logic        q_neg_reg;
    logic        r_neg_reg;
    logic [63:0] result_reg;

    // Operand conditioning: sign is only meaningful in signed mode.
    // abs(0x80000000) wraps to 0x80000000, which is read as unsigned 2^31.
    logic        s1, s2;
    logic [31:0] abs1, abs2;
    logic        divisor_zero;

    assign s1           = bus.div_sign & bus.opdata1_i[31];
    assign s2           = bus.div_sign & bus.opdata2_i[31];
    assign abs1         = s1 ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
    assign abs2         = s2 ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
    assign divisor_zero = (bus.opdata2_i == 32'd0);

    // One restoring step: shift left, trial-subtract the divisor from the
    // upper 33 bits. The partial remainder is always below the divisor, so
    // bit 32 of the 33-bit difference is a clean borrow/sign indicator.
    logic [32:0] upper33;
    logic [32:0] diff;
    logic [63:0] step_next;
    logic [31:0] quot_fix, rem_fix;

    assign upper33   = work_reg[63:31];
    assign diff      = upper33 - {1'b0, divisor_reg};
    assign step_next = diff[32] ? {work_reg[62:0], 1'b0}
                                : {diff[31:0], work_reg[30:0], 1'b1};
    assign quot_fix  = q_neg_reg ? (~step_next[31:0] + 32'd1)  : step_next[31:0];
    assign rem_fix   = r_neg_reg ? (~step_next[63:32] + 32'd1) : step_next[63:32];

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; losing start_i anywhere returns to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start_i) begin
                    state_next = divisor_zero ? DIVZERO : ON;
                end
            end
            DIVZERO: begin
                state_next = bus.start_i ? END : IDLE;
            end
            ON: begin
                if (!bus.start_i) begin
                    state_next = IDLE;
                end else if (cnt_reg == 5'd31) begin
                    state_next = END;
                end
            end
            END: begin
                if (!bus.start_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result load on completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg     <= 5'd0;
            work_reg    <= 64'd0;
            divisor_reg <= 32'd0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            result_reg  <= 64'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start_i && !divisor_zero) begin
                        work_reg    <= {32'd0, abs1};
                        divisor_reg <= abs2;
                        q_neg_reg   <= s1 ^ s2;
                        r_neg_reg   <= s1;
                        cnt_reg     <= 5'd0;
                    end
                end
                DIVZERO: begin
                    if (bus.start_i) begin
                        result_reg <= 64'd0;
                    end
                end
                ON: begin
                    if (bus.start_i) begin
                        work_reg <= step_next;
                        cnt_reg  <= cnt_reg + 5'd1;
                        if (cnt_reg == 5'd31) begin
                            result_reg <= {rem_fix, quot_fix};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result_o = result_reg;
    assign bus.ready_o  = (state_reg == END);
endmodule

// File: tb/tb_div_plus.sv
// Directed bench for div_plus: table of hand-computed vectors plus
// hand-written abort and mid-operation reset sequences.
module tb_div_plus;
    logic clk;
    logic resetn;

    div_plus_if bus ();

    div_plus dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs [12];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request, measure latency, check the result, the hold
    // behaviour with start_i still high, and the return to IDLE.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input string name);
        int   k;
        logic seen;
        @(posedge clk); #1;
        bus.start_i   = 1'b1;
        bus.div_sign  = sgn;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        @(posedge clk); #1;            // acceptance edge E0
        bus.opdata1_i = $urandom;      // operands are don't-care after E0
        bus.opdata2_i = $urandom;
        bus.div_sign  = ~sgn;
        k    = 1;
        seen = bus.ready_o;
        while (!seen && k < 100) begin
            @(posedge clk); #1;
            k++;
            seen = bus.ready_o;
        end
        check({name, " latency"}, 64'(k), 64'(lat));
        check({name, " result"}, bus.result_o, exp);
        @(posedge clk); #1;
        check({name, " ready held"}, {63'd0, bus.ready_o}, 64'd1);
        check({name, " result held"}, bus.result_o, exp);
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        check({name, " ready drop"}, {63'd0, bus.ready_o}, 64'd0);
        check({name, " result kept"}, bus.result_o, exp);
        $display("op %-18s sgn=%0d a=%h b=%h -> %h lat=%0d", name, sgn, a, b, bus.result_o, k);
    endtask

    initial begin
        logic seen;

        vecs[0]  = '{1'b0, 32'd100,       32'd7,        64'h00000002_0000000E, 33, "u100/7"};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33, "s-7/2"};
        vecs[2]  = '{1'b1, 32'h00000007,  32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, "s7/-2"};
        vecs[3]  = '{1'b0, 32'h00001234,  32'h00000000, 64'h00000000_00000000, 2,  "u0x1234/0"};
        vecs[4]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 64'h00000000_80000000, 33, "sMIN/-1"};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF,  32'h00000001, 64'h00000000_FFFFFFFF, 33, "uMAX/1"};
        vecs[6]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF, 64'h80000000_00000000, 33, "u2^31/MAX"};
        vecs[7]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33, "s-100/-7"};
        vecs[8]  = '{1'b0, 32'hFFFFFFF9,  32'h00000002, 64'h00000001_7FFFFFFC, 33, "u0xFFFFFFF9/2"};
        vecs[9]  = '{1'b1, 32'h00000005,  32'h00000007, 64'h00000005_00000000, 33, "s5/7"};
        vecs[10] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 64'h00000000_00000001, 33, "uMAX/MAX"};
        vecs[11] = '{1'b1, 32'h80000000,  32'h00000002, 64'h00000000_C0000000, 33, "sMIN/2"};

        resetn        = 1'b0;
        bus.start_i   = 1'b0;
        bus.div_sign  = 1'b0;
        bus.opdata1_i = 32'd0;
        bus.opdata2_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", bus.result_o, 64'd0);
        check("reset ready", {63'd0, bus.ready_o}, 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);
        end

        // Abort after iteration 10: no ready, result untouched.
        @(posedge clk); #1;
        bus.start_i   = 1'b1;
        bus.div_sign  = 1'b0;
        bus.opdata1_i = 32'h00001234;
        bus.opdata2_i = 32'h00000010;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.ready_o) seen = 1'b1;
        end
        check("abort ready", {63'd0, seen}, 64'd0);
        check("abort result", bus.result_o, 64'h00000000_C0000000);
        $display("op %-18s aborted at iteration 10, result=%h", "abort", bus.result_o);
        run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, "u100/7 post-abort");

        // Asynchronous reset in the middle of an iteration sequence.
        @(posedge clk); #1;
        bus.start_i   = 1'b1;
        bus.div_sign  = 1'b1;
        bus.opdata1_i = 32'hFFFFFFF9;
        bus.opdata2_i = 32'h00000002;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("midON reset result", bus.result_o, 64'd0);
        check("midON reset ready", {63'd0, bus.ready_o}, 64'd0);
        $display("op %-18s reset mid-ON, result=%h ready=%0d", "reset", bus.result_o, bus.ready_o);
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        run_op(1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, "s7/-2 post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
